// File: rtl/intr_ctrl.sv
// Parametrised interrupt controller. Edge-latches NUM_IRQ interrupt lines into
// pending bits, applies a per-source mask and a global enable, and presents the
// lowest-index eligible source to the CPU as a request plus a handler vector.
// The request is held until the CPU takes it. The controller then stays in service
// until software writes an ack.
//
// Optional build macro INTR_CTRL_LEVEL_EN: the pending bits follow the raw
// interrupt lines (level-sensitive), and taking a request does not clear its
// pending bit.
//
// VEC_W is expected to be at most 32, the width of the write data bus.

module intr_ctrl #(
    parameter int unsigned NUM_IRQ    = 8,
    parameter int unsigned VEC_W      = 32,
    parameter int unsigned VEC_STRIDE = 4,
    localparam int unsigned ID_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [31:0]        wr_data,
    input  logic               intr_take,
    output logic               intr_req,
    output logic [VEC_W-1:0]   intr_vec,
    output logic [ID_W-1:0]    intr_id,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StService
    } state_e;

    localparam logic [1:0] AddrAck  = 2'd0;
    localparam logic [1:0] AddrGen  = 2'd1;
    localparam logic [1:0] AddrBase = 2'd2;
    localparam logic [1:0] AddrMask = 2'd3;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               global_en_q, global_en_d;
    logic [VEC_W-1:0]   vec_base_q, vec_base_d;
    logic [ID_W-1:0]    intr_id_q, intr_id_d;

    logic [NUM_IRQ-1:0] eligible;
    logic               fire;
    logic               ack;
    logic               take_now;
    logic [ID_W-1:0]    lowest_id;

    // Only part of the write bus feeds the mask/base registers for small configs.
    logic unused_wr_data;
    assign unused_wr_data = ^wr_data;

    assign eligible = pending_q & mask_q;
    assign fire     = global_en_q & (|eligible);
    assign ack      = wr_en && (wr_addr == AddrAck) && wr_data[0];
    assign take_now = (state_q == StReq) && intr_take;

    // Fixed priority: scan downwards so the lowest set index is the last assignment.
    always_comb begin
        lowest_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lowest_id = ID_W'(i);
            end
        end
    end

`ifdef INTR_CTRL_LEVEL_EN
    // Level mode: pending mirrors the lines; software clears the device before ack.
    always_comb begin
        pending_d = irq_in;
    end
`else
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] irq_rise;

    assign irq_rise = irq_in & ~irq_prev_q;

    // Edge mode: a take clears the served bit, but a fresh rise on the same bit wins.
    always_comb begin
        pending_d = pending_q;
        if (take_now) begin
            pending_d[intr_id_q] = 1'b0;
        end
        pending_d = pending_d | irq_rise;
    end

    // Previous-sample register for rise detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev_q <= '0;
        end else begin
            irq_prev_q <= irq_in;
        end
    end
`endif

    // Software-visible configuration registers, written by the w_intr instruction.
    always_comb begin
        global_en_d = global_en_q;
        vec_base_d  = vec_base_q;
        mask_d      = mask_q;
        if (wr_en) begin
            unique case (wr_addr)
                AddrGen:  global_en_d = wr_data[0];
                AddrBase: vec_base_d  = wr_data[VEC_W-1:0];
                AddrMask: mask_d      = wr_data[NUM_IRQ-1:0];
                default:  ;
            endcase
        end
    end

    // Request/service FSM next state. The id is only captured when leaving idle,
    // so it stays stable through the request and the handler.
    always_comb begin
        state_d   = state_q;
        intr_id_d = intr_id_q;
        unique case (state_q)
            StIdle: begin
                if (fire) begin
                    intr_id_d = lowest_id;
                    state_d   = StReq;
                end
            end
            StReq: begin
                // Take beats retraction when both happen in the same cycle.
                if (intr_take) begin
                    state_d = StService;
                end else if (!global_en_q || !eligible[intr_id_q]) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and register update; reset abandons any request or handler.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            mask_q      <= '0;
            global_en_q <= 1'b0;
            vec_base_q  <= '0;
            intr_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            global_en_q <= global_en_d;
            vec_base_q  <= vec_base_d;
            intr_id_q   <= intr_id_d;
        end
    end

    // Outputs decode directly from registered state; the vector wraps modulo 2^VEC_W.
    always_comb begin
        intr_req   = (state_q == StReq);
        in_service = (state_q == StService);
        intr_id    = intr_id_q;
        pending    = pending_q;
        intr_vec   = vec_base_q + (VEC_W'(intr_id_q) * VEC_W'(VEC_STRIDE));
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios with literal expectations, then random
// traffic, all cross-checked every cycle against a behavioural model.
`timescale 1ns/1ps

module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  irq_in = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        intr_take = 1'b0;
    logic        intr_req;
    logic [31:0] intr_vec;
    logic [2:0]  intr_id;
    logic        in_service;
    logic [7:0]  pending;

    int checks = 0;
    int failures = 0;

    intr_ctrl #(
        .NUM_IRQ    (8),
        .VEC_W      (32),
        .VEC_STRIDE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .intr_take  (intr_take),
        .intr_req   (intr_req),
        .intr_vec   (intr_vec),
        .intr_id    (intr_id),
        .in_service (in_service),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase: 0 idle, 1 requesting, 2 handler running.
    logic [7:0]  m_pend = '0, m_mask = '0, m_prev = '0;
    logic        m_gen = 1'b0;
    logic [31:0] m_base = '0;
    int          m_id = 0;
    int          m_phase = 0;
    bit          m_valid = 1'b0;

    function automatic int first_set(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        logic [7:0] rise, elig, npend;
        int nphase, nid;
        if (reset) begin
            m_pend = '0; m_mask = '0; m_prev = '0; m_gen = 1'b0;
            m_base = '0; m_id = 0; m_phase = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            rise   = irq_in & ~m_prev;
            elig   = m_pend & m_mask;
            npend  = m_pend;
            nphase = m_phase;
            nid    = m_id;
            if (m_phase == 0 && m_gen && elig != 0) begin
                nid = first_set(elig);
                nphase = 1;
            end else if (m_phase == 1 && intr_take) begin
                npend[m_id] = 1'b0;
                nphase = 2;
            end else if (m_phase == 1 && (!m_gen || !elig[m_id])) begin
                nphase = 0;
            end else if (m_phase == 2 && wr_en && wr_addr == 2'd0 && wr_data[0]) begin
                nphase = 0;
            end
            m_pend  = npend | rise;
            m_prev  = irq_in;
            m_phase = nphase;
            m_id    = nid;
            if (wr_en && wr_addr == 2'd1) m_gen = wr_data[0];
            if (wr_en && wr_addr == 2'd2) m_base = wr_data;
            if (wr_en && wr_addr == 2'd3) m_mask = wr_data[7:0];
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("m_req", {31'd0, intr_req}, {31'd0, m_phase == 1});
            check("m_svc", {31'd0, in_service}, {31'd0, m_phase == 2});
            check("m_id", {29'd0, intr_id}, 32'(m_id));
            check("m_vec", intr_vec, m_base + 32'(m_id) * 32'd4);
            check("m_pend", {24'd0, pending}, {24'd0, m_pend});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0; wr_data = '0;
    endtask

    task automatic take();
        intr_take = 1'b1;
        tick();
        intr_take = 1'b0;
    endtask

    task automatic setup();
        wr(2'd3, 32'hFF);
        wr(2'd1, 32'h1);
        wr(2'd2, 32'h100);
    endtask

    initial begin
        #1;
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        check("rst_req", {31'd0, intr_req}, 32'd0);
        check("rst_pend", {24'd0, pending}, 32'd0);
        check("rst_vec", intr_vec, 32'd0);
        setup();

        // Single pulse on line 3.
        irq_in = 8'h08; tick(); irq_in = 8'h00;
        check("t1_pend", {24'd0, pending}, 32'h08);
        check("t1_req_early", {31'd0, intr_req}, 32'd0);
        tick();
        check("t1_req", {31'd0, intr_req}, 32'd1);
        check("t1_id", {29'd0, intr_id}, 32'd3);
        check("t1_vec", intr_vec, 32'h10C);
        take();
        check("t1_svc", {31'd0, in_service}, 32'd1);
        check("t1_pend_clr", {24'd0, pending}, 32'h00);
        wr(2'd0, 32'h1);
        check("t1_ack", {31'd0, in_service}, 32'd0);

        // Lines 5 and 2 together: 2 first, then 5 without a new edge.
        irq_in = 8'h24; tick(); irq_in = 8'h00; tick();
        check("t2_id2", {29'd0, intr_id}, 32'd2);
        check("t2_vec2", intr_vec, 32'h108);
        take(); wr(2'd0, 32'h1); tick();
        check("t2_req5", {31'd0, intr_req}, 32'd1);
        check("t2_id5", {29'd0, intr_id}, 32'd5);
        check("t2_vec5", intr_vec, 32'h114);
        take(); wr(2'd0, 32'h1);

        // Masked source latches and fires once unmasked.
        wr(2'd3, 32'h00);
        irq_in = 8'h02; tick(); irq_in = 8'h00; tick(); tick();
        check("t3_pend", {24'd0, pending}, 32'h02);
        check("t3_noreq", {31'd0, intr_req}, 32'd0);
        wr(2'd3, 32'h02); tick();
        check("t3_req", {31'd0, intr_req}, 32'd1);
        check("t3_id", {29'd0, intr_id}, 32'd1);
        take(); wr(2'd0, 32'h1); wr(2'd3, 32'hFF);

        // Retraction by global enable.
        irq_in = 8'h10; tick(); irq_in = 8'h00; tick();
        check("t4_req", {31'd0, intr_req}, 32'd1);
        wr(2'd1, 32'h0); tick();
        check("t4_retract", {31'd0, intr_req}, 32'd0);
        check("t4_pend", {24'd0, pending}, 32'h10);
        wr(2'd1, 32'h1); tick();
        check("t4_rereq", {31'd0, intr_req}, 32'd1);
        check("t4_id", {29'd0, intr_id}, 32'd4);
        take(); wr(2'd0, 32'h1);

        // New edge on the bit being taken: set wins.
        irq_in = 8'h08; tick(); irq_in = 8'h00; tick();
        irq_in = 8'h08; intr_take = 1'b1; tick(); intr_take = 1'b0; irq_in = 8'h00;
        check("t5_svc", {31'd0, in_service}, 32'd1);
        check("t5_pend", {24'd0, pending}, 32'h08);
        wr(2'd0, 32'h1); tick(); take(); wr(2'd0, 32'h1);

        // No nesting during service; reset mid-service.
        irq_in = 8'h02; tick(); irq_in = 8'h00; tick(); take();
        irq_in = 8'h01; tick(); irq_in = 8'h00; tick(); tick();
        check("t6_noreq", {31'd0, intr_req}, 32'd0);
        check("t6_svc", {31'd0, in_service}, 32'd1);
        check("t6_pend", {24'd0, pending}, 32'h01);
        wr(2'd0, 32'h1); tick();
        check("t6_req0", {31'd0, intr_req}, 32'd1);
        check("t6_id0", {29'd0, intr_id}, 32'd0);
        check("t6_vec0", intr_vec, 32'h100);
        take();
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_rst_svc", {31'd0, in_service}, 32'd0);
        check("t6_rst_req", {31'd0, intr_req}, 32'd0);
        check("t6_rst_vec", intr_vec, 32'd0);
        check("t6_rst_pend", {24'd0, pending}, 32'd0);

        // Ack in idle is ignored; a held line requests exactly once.
        setup();
        wr(2'd0, 32'h1);
        check("t7_idle_ack", {31'd0, intr_req | in_service}, 32'd0);
        irq_in = 8'h40; tick(); tick();
        check("t7_req", {31'd0, intr_req}, 32'd1);
        check("t7_id", {29'd0, intr_id}, 32'd6);
        take(); wr(2'd0, 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t7_once", {31'd0, intr_req}, 32'd0);
        end
        irq_in = 8'h00;

        // Random traffic, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            irq_in    = 8'($urandom & $urandom & $urandom);
            intr_take = ($urandom_range(0, 2) == 0);
            wr_en     = ($urandom_range(0, 6) == 0);
            wr_addr   = 2'($urandom_range(0, 3));
            wr_data   = $urandom;
            if (wr_addr == 2'd1) wr_data[0] = ($urandom_range(0, 4) != 0);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; wr_en = 1'b0; intr_take = 1'b0; irq_in = '0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Parametrised interrupt controller; successor to the CPU's single-bit ack/intr_en/intr_vec registers.
- Accepts NUM_IRQ external interrupt lines, latches them as pending, applies a per-source mask and a global enable, and arbitrates by fixed priority (lowest index wins).
- Presents one request plus a computed vector to the CPU and tracks in-service state until software acknowledges.
- Sits between mother_board peripherals (uart, timer, etc.) and cpu. The CPU's w_intr instruction drives the write port.

Parameters:
- NUM_IRQ, 8, number of interrupt sources (1..32).
- VEC_W, 32, width of the vector output and of the vector base register.
- VEC_STRIDE, 4, byte spacing between consecutive source vectors.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- irq_in, input, NUM_IRQ, raw interrupt lines, already synchronous to clk.
- wr_en, input, 1, register write strobe from the w_intr instruction.
- wr_addr, input, 2, register select: 0=ack, 1=global enable, 2=vector base, 3=mask.
- wr_data, input, 32, write data.
- intr_take, input, 1, CPU accepts the current request this cycle.
- intr_req, output, 1, interrupt request to the CPU.
- intr_vec, output, VEC_W, handler address: vec_base + intr_id*VEC_STRIDE, truncated to VEC_W.
- intr_id, output, $clog2(NUM_IRQ) (min 1), index of the requested or in-service source.
- in_service, output, 1, a handler is running and has not been acked.
- pending, output, NUM_IRQ, pending bit vector.

Behaviour:
- Reset (synchronous):
  - Clears irq_prev, pending, mask, global_en, vec_base and intr_id.
  - State goes to IDLE; intr_req=0, in_service=0, intr_vec=0.
  - A reset in any state, including REQ and SERVICE, aborts with no ack required.
- Edge detection:
  - irq_prev <= irq_in every cycle.
  - A rise (irq_in & ~irq_prev) sampled at edge k sets the pending bit after edge k.
  - A held-high line sets pending only once.
- Writes (wr_en=1, effective the next cycle):
  - addr 1: global_en <= wr_data[0].
  - addr 2: vec_base <= wr_data[VEC_W-1:0].
  - addr 3: mask <= wr_data[NUM_IRQ-1:0].
  - addr 0 with wr_data[0]=1 is an ack; it is ignored outside SERVICE.
- Eligibility: eligible = pending & mask; fire = global_en & |eligible.
- FSM:
  - IDLE: if fire, latch intr_id = lowest set bit of eligible and go to REQ.
  - REQ:
    - intr_req=1; intr_id and intr_vec stay stable even if a higher-priority source becomes pending.
    - If intr_take=1, clear pending[intr_id] and go to SERVICE.
    - Otherwise, if global_en=0 or eligible[intr_id]=0, retract: go to IDLE, intr_req drops next cycle.
    - intr_take takes precedence over retraction in the same cycle.
  - SERVICE: in_service=1, intr_req=0, no nesting; ack moves to IDLE. Pending bits keep accumulating.
  - Back-to-back: fire in the IDLE cycle after an ack gives REQ on the following edge.
- Latency: a rise sampled at edge k gives intr_req high after edge k+1 (2 cycles from the line rising).
- Simultaneous new edge and take-clear on the same pending bit: the set wins and the bit stays 1.
- Masked sources still latch pending and fire once unmasked.
- intr_vec is combinational from vec_base and the registered intr_id. Addition wraps modulo 2^VEC_W.

Optional Feature:
- INTR_CTRL_LEVEL_EN
- Defined:
  - Edge detection is removed; pending = irq_in (level).
  - intr_take does not clear pending; software clears the source device before ack.
  - If the line is still high at ack, the controller re-requests 2 cycles later.
- Undefined: edge-latched behaviour as above.

Test Plan:
- Reset, write mask=0xFF, global_en=1, vec_base=0x100; pulse irq_in[3] one cycle -> intr_req=1 two cycles later, intr_id=3, intr_vec=0x10C; intr_take -> pending[3]=0, in_service=1; ack -> in_service=0, IDLE.
- Raise irq_in[5] and irq_in[2] in the same cycle -> id=2 served first (vec 0x108); after ack, id=5 is requested (vec 0x114) with no new edge.
- mask=0x00, pulse irq_in[1] -> pending=0x02, intr_req stays 0; write mask=0x02 -> intr_req=1, id=1.
- In REQ for id 4, write global_en=0 -> intr_req=0 next cycle, pending[4] still 1; global_en=1 -> re-request id 4.
- During SERVICE, pulse irq_in[0] -> no intr_req until ack; then id=0 is requested. Assert reset mid-SERVICE -> all outputs 0 next cycle.
- Ack written in IDLE -> no state change. irq_in held high 10 cycles -> exactly one request.
